// File: rtl/reg_writeback_queue.sv
// reg_writeback_queue
// Write-side front end for the 32x64 register file. Accepts results from the
// memory/load path and the ALU, holds them in a small in-order queue and
// drains one entry per cycle onto the register file's synchronous write port.
// Writes to register 0 are accepted and discarded (X0 is hardwired zero).
// Optional feature, macro WBQ_FORWARD_EN: combinational forwarding of pending
// values to two decode read indices. With the macro undefined HIT_x and
// FWD_DATA_x are tied to zero and no search logic exists.
module reg_writeback_queue #(
   parameter int DEPTH      = 4,
   parameter int DATA_WIDTH = 64,
   parameter int ADDR_WIDTH = 5
) (
   input  logic                         CLK,
   input  logic                         RST_N,
   input  logic                         MEM_VALID,
   input  logic [ADDR_WIDTH-1:0]        MEM_REG,
   input  logic [DATA_WIDTH-1:0]        MEM_DATA,
   output logic                         MEM_READY,
   input  logic                         ALU_VALID,
   input  logic [ADDR_WIDTH-1:0]        ALU_REG,
   input  logic [DATA_WIDTH-1:0]        ALU_DATA,
   output logic                         ALU_READY,
   output logic [ADDR_WIDTH-1:0]        WRITE_REG,
   output logic [DATA_WIDTH-1:0]        WRITE_DATA,
   output logic                         REG_WRITE_ENABLE,
   output logic [$clog2(DEPTH+1)-1:0]   COUNT,
   input  logic [ADDR_WIDTH-1:0]        LOOKUP_REG_A,
   input  logic [ADDR_WIDTH-1:0]        LOOKUP_REG_B,
   output logic                         HIT_A,
   output logic                         HIT_B,
   output logic [DATA_WIDTH-1:0]        FWD_DATA_A,
   output logic [DATA_WIDTH-1:0]        FWD_DATA_B
);

   localparam int CW = $clog2(DEPTH + 1);
   localparam int PW = $clog2(DEPTH);
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   // queue storage
   logic [ADDR_WIDTH-1:0] r_reg_q  [DEPTH];
   logic [DATA_WIDTH-1:0] r_data_q [DEPTH];

   logic [PW-1:0]         r_head;
   logic [PW-1:0]         r_tail;
   logic [CW-1:0]         r_count;
   logic                  r_wen;
   logic [ADDR_WIDTH-1:0] r_wreg;
   logic [DATA_WIDTH-1:0] r_wdata;

   logic [CW-1:0]         w_free;
   logic                  w_mem_fire;
   logic                  w_alu_fire;
   logic                  w_mem_store;
   logic                  w_alu_store;
   logic                  w_pop;
   logic [PW-1:0]         w_alu_slot;

   // Free space uses the registered count only: a same-cycle pop is not
   // credited, so a full queue refuses pushes even while it drains.
   assign w_free    = DEPTH_C - r_count;
   assign MEM_READY = (w_free >= CW'(1));
   // MEM carries the older instruction, so it owns the last free slot.
   assign ALU_READY = (w_free >= CW'(2)) ||
                      ((w_free == CW'(1)) && !(MEM_VALID && (MEM_REG != '0)));

   assign w_mem_fire  = MEM_VALID && MEM_READY;
   assign w_alu_fire  = ALU_VALID && ALU_READY;
   assign w_mem_store = w_mem_fire && (MEM_REG != '0);
   assign w_alu_store = w_alu_fire && (ALU_REG != '0);
   assign w_pop       = (r_count != '0);
   // ALU lands behind the MEM entry when both are stored this cycle.
   assign w_alu_slot  = w_mem_store ? (r_tail + PW'(1)) : r_tail;

   // Write accepted non-zero results into the queue slots.
   // NOTE: the payload array has no reset; occupancy is tracked by r_count,
   // so stale contents are never observed and the RAM stays reset-free.
   always_ff @(posedge CLK) begin
      if (w_mem_store) begin
         r_reg_q[r_tail]  <= MEM_REG;
         r_data_q[r_tail] <= MEM_DATA;
      end
      if (w_alu_store) begin
         r_reg_q[w_alu_slot]  <= ALU_REG;
         r_data_q[w_alu_slot] <= ALU_DATA;
      end
   end

   // Advance pointers and count; drain the head onto the write port.
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
         r_wen   <= 1'b0;
         r_wreg  <= '0;
         r_wdata <= '0;
      end else begin
         r_tail  <= r_tail + PW'(w_mem_store) + PW'(w_alu_store);
         r_count <= r_count + CW'(w_mem_store) + CW'(w_alu_store) - CW'(w_pop);
         if (w_pop) begin
            r_wen   <= 1'b1;
            r_wreg  <= r_reg_q[r_head];
            r_wdata <= r_data_q[r_head];
            r_head  <= r_head + PW'(1);
         end else begin
            r_wen   <= 1'b0;
         end
      end
   end

   assign WRITE_REG        = r_wreg;
   assign WRITE_DATA       = r_wdata;
   assign REG_WRITE_ENABLE = r_wen;
   assign COUNT            = r_count;

`ifdef WBQ_FORWARD_EN
   // Search oldest to youngest so the youngest match overwrites earlier ones:
   // output register first, then queue entries from head towards tail.
   function automatic logic [DATA_WIDTH:0] f_search(input logic [ADDR_WIDTH-1:0] idx);
      logic [DATA_WIDTH:0] res;
      logic [PW-1:0]       slot;
      res = '0;
      if (idx != '0) begin
         if (r_wen && (r_wreg == idx)) res = {1'b1, r_wdata};
         for (int i = 0; i < DEPTH; i++) begin
            slot = r_head + PW'(i);
            if ((CW'(i) < r_count) && (r_reg_q[slot] == idx))
               res = {1'b1, r_data_q[slot]};
         end
      end
      return res;
   endfunction

   // Forwarding lookups for both decode read ports.
   // NOTE: outputs get a full default inside the function before any
   // conditional update, so no latch is inferred.
   always_comb begin
      {HIT_A, FWD_DATA_A} = f_search(LOOKUP_REG_A);
      {HIT_B, FWD_DATA_B} = f_search(LOOKUP_REG_B);
   end
`else
   logic w_unused_lookup;
   assign w_unused_lookup = ^{LOOKUP_REG_A, LOOKUP_REG_B};
   assign HIT_A      = 1'b0;
   assign HIT_B      = 1'b0;
   assign FWD_DATA_A = '0;
   assign FWD_DATA_B = '0;
`endif

endmodule
